pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, flush, bubble zeroing of control bits and an optional skid buffer. It is the generalised successor to the fixed stage registers between decode and execute. It carries any control/data bundle split into a control field and a data field, and adds back-pressure, squash and stall accounting. Instances sit between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_stall_counter.sv | 39 +++
 rtl/pipe_stage_skid.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the pipeline stage registers:
//   - pipe_state_e : stage occupancy state (EMPTY / BUSY / FULL)
//   - OCC_*        : 2-bit occupancy encoding reported on the occupancy port
//   - *_W          : field widths used by stage wrappers to pack DATA_W
//   - occ_of()     : maps a state to its occupancy count
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no live entries
    ST_BUSY  = 2'd1,  // main register only
    ST_FULL  = 2'd2   // main + skid (skid builds only)
  } pipe_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Stage bundle field widths (opcode, immediate, register index, operand).
  localparam int OPCODE_W  = 5;
  localparam int IMM_W     = 8;
  localparam int REG_IDX_W = 3;
  localparam int OPERAND_W = 32;

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (s)
      ST_BUSY: occ = OCC_BUSY;
      ST_FULL: occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// pipe_stall_counter
//   Saturating up-counter with synchronous clear; clear wins over increment.
//   Ports:
//     clk, rst : clock (rising edge), asynchronous active-high reset
//     inc      : count this cycle (held at all-ones once reached)
//     clr      : synchronous clear to zero
//     count    : current count
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Pipeline stage register with valid/ready handshake, flush, bubble zeroing
//   of the control field and an optional second (skid) entry.
//   Ports:
//     clk, rst               : clock (rising edge), asynchronous active-high reset
//     in_valid/in_ready      : upstream handshake
//     in_ctrl/in_data        : upstream bundle (control field / data field)
//     out_valid/out_ready    : downstream handshake
//     out_ctrl/out_data      : head bundle; out_ctrl is zero while not valid,
//                              out_data keeps its last value
//     flush                  : squash every held entry at this edge
//     occupancy              : live entry count (0..2)
//     stall_cycles/stall_clr : saturating count of out_valid & !out_ready cycles
//   SKID=1: two entries, in_ready comes straight from a flop.
//   SKID=0: one entry, in_ready = out_ready | empty (combinational).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  input  logic              stall_clr
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_load   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d     = ST_BUSY;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (in_fire) begin
          // Head is blocked: park the newcomer behind it.
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          // Bubble: control goes to zero, data is left as-is.
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d     = ST_BUSY;
          main_ctrl_d = skid_ctrl;
          main_data_d = skid_data;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        main_ctrl_d = '0;
      end
    endcase
    // Flush beats every other transition; any bundle arriving now is dropped
    // and the data register is left untouched.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;
      logic              in_ready_q;

      always_comb begin
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
          skid_ctrl_d = '0;
        end else if (skid_load) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end
      end

      // in_ready is the registered image of "next state is not FULL", so it
      // has no combinational dependence on any input.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
          in_ready_q  <= 1'b1;
        end else begin
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
          in_ready_q  <= (state_d != ST_FULL);
        end
      end

      assign skid_ctrl = skid_ctrl_q;
      assign skid_data = skid_data_q;
      assign in_ready  = in_ready_q;
    end else begin : g_no_skid
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign in_ready  = out_ready | (state_q == ST_EMPTY);
    end
  endgenerate

  pipe_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .clr  (stall_clr),
    .count(stall_cycles)
  );

  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Drives two instances from the same stimulus: u_skid (SKID=1, CNT_W=16)
//   and u_noskid (SKID=0, CNT_W=2). Each is tracked by a FIFO reference
//   model (entry count + ordered entry list + stall count).
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, flush, stall_clr;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;

  logic        ir0, ov0, ir1, ov1;
  logic [7:0]  oc0, oc1;
  logic [63:0] od0, od1;
  logic [1:0]  occ0, occ1;
  logic [15:0] st0;
  logic [1:0]  st1;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(64), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0),
    .out_data(od0), .flush(flush), .occupancy(occ0), .stall_cycles(st0),
    .stall_clr(stall_clr)
  );

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(64), .SKID(0), .CNT_W(2)) u_noskid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1),
    .out_data(od1), .flush(flush), .occupancy(occ1), .stall_cycles(st1),
    .stall_clr(stall_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per instance, an ordered list of up to two entries.
  int          cnt    [2];
  logic [7:0]  e_ctrl [2][2];
  logic [63:0] e_data [2][2];
  logic [63:0] last_d [2];
  int          stall  [2];
  logic        obs_ir [2];
  logic        exp_ir [2];
  logic        fired_in [2];
  logic        fired_out[2];
  logic [63:0] out_log[$];

  function automatic int cap(input int m);
    return (m == 0) ? 2 : 1;
  endfunction

  function automatic int smax(input int m);
    return (m == 0) ? 65535 : 3;
  endfunction

  function automatic logic model_ready(input int m);
    if (m == 0) return (cnt[m] < cap(m));
    return out_ready || (cnt[m] == 0);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0; last_d[m] = '0; stall[m] = 0;
    end
  endtask

  task automatic get_out(input int m, output logic v, output logic [7:0] c,
                         output logic [63:0] d, output logic [1:0] o, output int s);
    if (m == 0) begin v = ov0; c = oc0; d = od0; o = occ0; s = int'(st0); end
    else        begin v = ov1; c = oc1; d = od1; o = occ1; s = int'(st1); end
  endtask

  // One clock: inputs are already set; capture in_ready before the edge,
  // advance the model by the handshake rules, land 1ns after the edge.
  task automatic step();
    logic inc[2];
    #1;
    for (int m = 0; m < 2; m++) begin
      obs_ir[m]    = (m == 0) ? ir0 : ir1;
      exp_ir[m]    = model_ready(m);
      fired_in[m]  = in_valid && exp_ir[m];
      fired_out[m] = (cnt[m] > 0) && out_ready;
      inc[m]       = (cnt[m] > 0) && !out_ready;
      if (m == 0 && ov0 && out_ready) out_log.push_back(od0);
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (cnt[m] > 0) last_d[m] = e_data[m][0];
      if (flush) begin
        cnt[m] = 0;
      end else begin
        if (fired_out[m]) begin
          e_ctrl[m][0] = e_ctrl[m][1];
          e_data[m][0] = e_data[m][1];
          cnt[m]--;
        end
        if (fired_in[m]) begin
          e_ctrl[m][cnt[m]] = in_ctrl;
          e_data[m][cnt[m]] = in_data;
          cnt[m]++;
        end
      end
      if (stall_clr) stall[m] = 0;
      else if (inc[m] && stall[m] < smax(m)) stall[m]++;
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush = 0; stall_clr = 0; in_ctrl = '0; in_data = '0;
  endtask

  task automatic test_reset();
    logic v; logic [7:0] c; logic [63:0] d; logic [1:0] o; int s;
    idle_inputs();
    rst = 1'b1;
    #3;
    for (int m = 0; m < 2; m++) begin
      get_out(m, v, c, d, o, s);
      n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", m, v); end
      n_checks++; if (c !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl[%0d] got %h want 00", m, c); end
      n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_data[%0d] got %h want 0", m, d); end
      n_checks++; if (o !== 2'd0) begin n_fail++; $display("FAIL reset_occ[%0d] got %0d want 0", m, o); end
      n_checks++; if (s !== 0) begin n_fail++; $display("FAIL reset_stall[%0d] got %0d want 0", m, s); end
    end
    n_checks++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir0); end
    #9 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic v; logic [7:0] c; logic [63:0] d; logic [1:0] o; int s;
    in_valid = 1; in_ctrl = 8'hA5; in_data = 64'h1234; out_ready = 1;
    step();
    in_valid = 0;
    for (int m = 0; m < 2; m++) begin
      get_out(m, v, c, d, o, s);
      n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got %b want 1", m, v); end
      n_checks++; if (c !== 8'hA5) begin n_fail++; $display("FAIL basic_ctrl[%0d] got %h want a5", m, c); end
      n_checks++; if (d !== 64'h1234) begin n_fail++; $display("FAIL basic_data[%0d] got %h want 1234", m, d); end
      n_checks++; if (o !== 2'd1) begin n_fail++; $display("FAIL basic_occ[%0d] got %0d want 1", m, o); end
    end
    step();  // drain: bubble zeroes ctrl, data held
    for (int m = 0; m < 2; m++) begin
      get_out(m, v, c, d, o, s);
      n_checks++; if (v !== 1'b0 || c !== 8'h00) begin n_fail++; $display("FAIL bubble_ctrl[%0d] got v=%b c=%h want v=0 c=00", m, v, c); end
      n_checks++; if (d !== 64'h1234) begin n_fail++; $display("FAIL bubble_data_hold[%0d] got %h want 1234", m, d); end
    end
    $display("test_basic: out 0xA5/0x1234 then bubble");
  endtask

  task automatic test_skid_stream();
    logic v; logic [7:0] c; logic [63:0] d; logic [1:0] o; int s;
    int idx = 0;
    out_log.delete();
    for (int cyc = 0; cyc < 10; cyc++) begin
      out_ready = (cyc < 1) || (cyc >= 6);
      in_valid  = (idx < 3);
      in_ctrl   = 8'(idx + 1);
      in_data   = 64'(idx + 1);
      step();
      if (fired_in[0]) idx++;
      n_checks++; if (obs_ir[0] !== exp_ir[0]) begin n_fail++; $display("FAIL stream_in_ready cyc%0d got %b want %b", cyc, obs_ir[0], exp_ir[0]); end
      if (cyc >= 2 && cyc <= 5) begin
        n_checks++; if (ir0 !== 1'b0 || occ0 !== 2'd2) begin n_fail++; $display("FAIL stream_full cyc%0d got ir=%b occ=%0d want ir=0 occ=2", cyc, ir0, occ0); end
      end
      for (int m = 0; m < 2; m++) begin
        get_out(m, v, c, d, o, s);
        n_checks++;
        if (v !== (cnt[m] > 0) || o !== 2'(cnt[m]) || s !== stall[m] ||
            c !== ((cnt[m] > 0) ? e_ctrl[m][0] : 8'h00) ||
            d !== ((cnt[m] > 0) ? e_data[m][0] : last_d[m])) begin
          n_fail++;
          $display("FAIL stream_out[%0d] cyc%0d got v=%b c=%h d=%h occ=%0d st=%0d want v=%0d occ=%0d st=%0d",
                   m, cyc, v, c, d, o, s, cnt[m] > 0, cnt[m], stall[m]);
        end
      end
    end
    n_checks++;
    if (out_log.size() != 3 || out_log[0] !== 64'd1 || out_log[1] !== 64'd2 || out_log[2] !== 64'd3) begin
      n_fail++; $display("FAIL stream_order got %0d items want 1,2,3", out_log.size());
    end
    in_valid = 0;
    $display("test_skid_stream: %0d bundles delivered in order", out_log.size());
  endtask

  task automatic test_flush_full();
    out_ready = 0; in_valid = 1;
    in_ctrl = 8'h11; in_data = 64'h11; step();
    in_ctrl = 8'h22; in_data = 64'h22; step();
    n_checks++; if (occ0 !== 2'd2) begin n_fail++; $display("FAIL flush_prefill_occ got %0d want 2", occ0); end
    flush = 1; in_ctrl = 8'h33; in_data = 64'h33; step();
    flush = 0; in_valid = 0;
    n_checks++; if (ov0 !== 1'b0 || oc0 !== 8'h00 || occ0 !== 2'd0) begin n_fail++; $display("FAIL flush_state got v=%b c=%h occ=%0d want 0/00/0", ov0, oc0, occ0); end
    n_checks++; if (ov1 !== 1'b0 || oc1 !== 8'h00 || occ1 !== 2'd0) begin n_fail++; $display("FAIL flush_state_noskid got v=%b c=%h occ=%0d want 0/00/0", ov1, oc1, occ1); end
    n_checks++; if (od0 !== last_d[0]) begin n_fail++; $display("FAIL flush_data_hold got %h want %h", od0, last_d[0]); end
    n_checks++; if (st0 !== 16'(stall[0])) begin n_fail++; $display("FAIL flush_keeps_stall got %0d want %0d", st0, stall[0]); end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL flush_ghost k%0d got valid=%b data=%h want 0", k, ov0, od0); end
    end
    $display("test_flush_full: stage empty after flush");
  endtask

  task automatic test_skid0_toggle();
    logic seq[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int xfers = 0;
    int ready_cycles = 0;
    in_valid = 1;
    for (int k = 0; k < 6; k++) begin
      out_ready = seq[k];
      in_ctrl = 8'(8'h40 + k); in_data = 64'(100 + k);
      step();
      n_checks++; if (obs_ir[1] !== exp_ir[1]) begin n_fail++; $display("FAIL noskid_in_ready k%0d got %b want %b", k, obs_ir[1], exp_ir[1]); end
      if (fired_out[1]) xfers++;
      if (seq[k]) ready_cycles++;
      n_checks++;
      if (ov1 !== (cnt[1] > 0) || oc1 !== ((cnt[1] > 0) ? e_ctrl[1][0] : 8'h00) || od1 !== ((cnt[1] > 0) ? e_data[1][0] : last_d[1])) begin
        n_fail++; $display("FAIL noskid_out k%0d got v=%b c=%h d=%h want v=%0d", k, ov1, oc1, od1, cnt[1] > 0);
      end
    end
    // Stage was busy entering this test's second cycle onward, so every ready
    // cycle except the first (stage empty) completes a transfer.
    n_checks++; if (xfers != ready_cycles - 1) begin n_fail++; $display("FAIL noskid_throughput got %0d want %0d", xfers, ready_cycles - 1); end
    in_valid = 0; out_ready = 1; step(); step();
    $display("test_skid0_toggle: %0d transfers over %0d ready cycles", xfers, ready_cycles);
  endtask

  task automatic test_stall_sat();
    stall_clr = 1; step(); stall_clr = 0;
    in_valid = 1; out_ready = 0; in_ctrl = 8'h77; in_data = 64'h77; step();
    in_valid = 0;
    for (int k = 0; k < 6; k++) step();
    n_checks++; if (st1 !== 2'd3) begin n_fail++; $display("FAIL stall_saturate got %0d want 3", st1); end
    n_checks++; if (st0 !== 16'd6) begin n_fail++; $display("FAIL stall_count got %0d want 6", st0); end
    stall_clr = 1; step(); stall_clr = 0;
    n_checks++; if (st1 !== 2'd0 || st0 !== 16'd0) begin n_fail++; $display("FAIL stall_clear got %0d/%0d want 0/0", st0, st1); end
    out_ready = 1; step();
    $display("test_stall_sat: saturated at 3, cleared");
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1;
    in_ctrl = 8'h5A; in_data = 64'hAA; step();
    in_ctrl = 8'h5B; in_data = 64'hBB; step();
    in_valid = 0;
    n_checks++; if (occ0 !== 2'd2) begin n_fail++; $display("FAIL areset_prefill got %0d want 2", occ0); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ov0 !== 1'b0 || occ0 !== 2'd0 || ir0 !== 1'b1) begin n_fail++; $display("FAIL areset_immediate got v=%b occ=%0d ir=%b want 0/0/1", ov0, occ0, ir0); end
    n_checks++; if (oc0 !== 8'h00 || od0 !== 64'h0 || st0 !== 16'd0) begin n_fail++; $display("FAIL areset_values got c=%h d=%h st=%0d want 0", oc0, od0, st0); end
    n_checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin n_fail++; $display("FAIL areset_noskid got v=%b occ=%0d want 0/0", ov1, occ1); end
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    $display("test_async_reset: outputs dropped before next edge");
  endtask

  task automatic test_random();
    logic v; logic [7:0] c; logic [63:0] d; logic [1:0] o; int s;
    int bad = 0;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      stall_clr = ($urandom_range(0, 29) == 0);
      in_ctrl   = 8'($urandom);
      in_data   = {$urandom, $urandom};
      step();
      for (int m = 0; m < 2; m++) begin
        get_out(m, v, c, d, o, s);
        n_checks++;
        if (obs_ir[m] !== exp_ir[m] || v !== (cnt[m] > 0) || o !== 2'(cnt[m]) || s !== stall[m] ||
            c !== ((cnt[m] > 0) ? e_ctrl[m][0] : 8'h00) ||
            d !== ((cnt[m] > 0) ? e_data[m][0] : last_d[m])) begin
          n_fail++; bad++;
          if (bad < 10)
            $display("FAIL random[%0d] k%0d got ir=%b v=%b c=%h d=%h occ=%0d st=%0d want ir=%b v=%0d occ=%0d st=%0d",
                     m, k, obs_ir[m], v, c, d, o, s, exp_ir[m], cnt[m] > 0, cnt[m], stall[m]);
        end
      end
    end
    idle_inputs();
    $display("test_random: 400 cycles, %0d mismatching cycles", bad);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid_stream();
    test_flush_full();
    test_skid0_toggle();
    test_stall_sat();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
